// File: rtl/calc_seq_ctrl.sv
// Sequencing controller for the shared 8-bit adder: single-pass add/sub,
// 8-step shift-add multiply and 8-step restoring divide over the same adder.
module calc_seq_ctrl #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] result,
  output logic           ovf,
  output logic           div_by_zero,
  output logic [N-1:0]   add_a,
  output logic [N-1:0]   add_b,
  output logic           add_cin,
  input  logic [N-1:0]   add_s,
  input  logic           add_cout,
  input  logic           add_ovr,
  output logic [2:0]     state_dbg
);

  localparam int CW = $clog2(N);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDSUB = 3'd1,
    S_MUL    = 3'd2,
    S_DIV    = 3'd3,
    S_DONE   = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic             sub_q, sub_d;
  logic [N-1:0]     b_q, b_d;
  logic [N-1:0]     hi_q, hi_d;   // PH for multiply, R for divide
  logic [N-1:0]     lo_q, lo_d;   // A for add/sub, PL for multiply, Q for divide
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   result_q, result_d;
  logic             ovf_q, ovf_d;
  logic             dbz_q, dbz_d;
  logic [N-1:0]     div_t;
  logic             qbit;

  // Handshake: start is taken only on an edge where busy=0; the result is
  // valid in the single cycle done=1 and stays on result until the next accept.
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign result      = result_q;
  assign ovf         = ovf_q;
  assign div_by_zero = dbz_q;
  assign state_dbg   = state_q;

  assign div_t = {hi_q[N-2:0], lo_q[N-1]};
  // The bit shifted out of R means T >= 2^N, so the subtraction always fits.
  assign qbit  = add_cout | hi_q[N-1];

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      S_ADDSUB: begin
        add_a   = lo_q;
        add_b   = sub_q ? ~b_q : b_q;
        add_cin = sub_q;
      end
      S_MUL: begin
        add_a = hi_q;
        add_b = lo_q[0] ? b_q : '0;
      end
      S_DIV: begin
        add_a   = div_t;
        add_b   = ~b_q;
        add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sub_d    = sub_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sub_d = op[0];
          b_d   = b;
          hi_d  = '0;
          lo_d  = a;
          cnt_d = '0;
          ovf_d = 1'b0;
          dbz_d = 1'b0;
          case (op)
            2'b10: state_d = S_MUL;
            2'b11: begin
              if (b == '0) begin
                state_d  = S_DONE;
                dbz_d    = 1'b1;
                result_d = {a, {N{1'b1}}};
              end else begin
                state_d = S_DIV;
              end
            end
            default: state_d = S_ADDSUB;
          endcase
        end
      end
      S_ADDSUB: begin
        result_d = {{N{add_s[N-1]}}, add_s};
        ovf_d    = add_ovr;
        state_d  = S_DONE;
      end
      S_MUL, S_DIV: begin
        if (state_q == S_MUL) begin
          hi_d = {add_cout, add_s[N-1:1]};
          lo_d = {add_s[0], lo_q[N-1:1]};
        end else begin
          hi_d = qbit ? add_s : div_t;
          lo_d = {lo_q[N-2:0], qbit};
        end
        if (cnt_q == CW'(N-1)) begin
          cnt_d    = '0;
          result_d = {hi_d, lo_d};
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sub_q    <= 1'b0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sub_q    <= sub_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

endmodule
